// File: rtl/operand_stage_if.sv
// operand_stage_if: ID/MEM/WB-side inputs and EX-side registered outputs of the operand stage
interface operand_stage_if #(parameter int XLEN = 32, parameter int CTRL_W = 8);
  logic              id_valid;
  logic [4:0]        id_rs1, id_rs2, id_rd;
  logic              id_reg_write, id_mem_read;
  logic [XLEN-1:0]   id_imm, id_pc;
  logic [CTRL_W-1:0] id_ctrl;
  logic [XLEN-1:0]   rf_rdata1, rf_rdata2;
  logic              mem_valid, mem_reg_write, mem_fwd_valid;
  logic [4:0]        mem_rd;
  logic [XLEN-1:0]   mem_result;
  logic              wb_reg_write;
  logic [4:0]        wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              ex_ready, flush;
  logic              id_stall;
  logic              ex_valid, ex_reg_write, ex_mem_read;
  logic [4:0]        ex_rd;
  logic [XLEN-1:0]   ex_op1, ex_op2, ex_imm, ex_pc;
  logic [CTRL_W-1:0] ex_ctrl;
  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_imm, id_pc, id_ctrl,
           rf_rdata1, rf_rdata2, mem_valid, mem_reg_write, mem_fwd_valid, mem_rd, mem_result,
           wb_reg_write, wb_rd, wb_data, ex_ready, flush,
    input  id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_op1, ex_op2, ex_imm, ex_pc, ex_ctrl
  );
  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, id_imm, id_pc, id_ctrl,
           rf_rdata1, rf_rdata2, mem_valid, mem_reg_write, mem_fwd_valid, mem_rd, mem_result,
           wb_reg_write, wb_rd, wb_data, ex_ready, flush,
    output id_stall, ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_op1, ex_op2, ex_imm, ex_pc, ex_ctrl
  );
endinterface

// File: rtl/operand_stage.sv
// operand_stage: ID/EX register with MEM/WB bypass, load-use stall and EX backpressure/flush
module operand_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8
) (
  input logic             clk,
  input logic             reset,
  operand_stage_if.slave  bus
);
  logic            mem_fwd, mem_pend, ex_load;
  logic            haz1, haz2, hazard;
  logic [XLEN-1:0] op1, op2;
  // MEM may bypass only once its result is final; a load still in MEM is a pending producer
  always_comb begin
    mem_fwd  = bus.mem_valid & bus.mem_reg_write & bus.mem_fwd_valid;
    mem_pend = bus.mem_valid & bus.mem_reg_write & ~bus.mem_fwd_valid;
    ex_load  = bus.ex_valid & bus.ex_mem_read & bus.ex_reg_write;
  end
  // Operand select: x0, then MEM, then WB (register file has no write-through), then RF
  always_comb begin
    op1 = (bus.id_rs1 == 5'd0) ? '0 :
          (mem_fwd && bus.mem_rd == bus.id_rs1) ? bus.mem_result :
          (bus.wb_reg_write && bus.wb_rd == bus.id_rs1) ? bus.wb_data : bus.rf_rdata1;
    op2 = (bus.id_rs2 == 5'd0) ? '0 :
          (mem_fwd && bus.mem_rd == bus.id_rs2) ? bus.mem_result :
          (bus.wb_reg_write && bus.wb_rd == bus.id_rs2) ? bus.wb_data : bus.rf_rdata2;
  end
  // Load-use hazard: a load in EX or an unfinished load in MEM produces a needed source
  always_comb begin
    haz1   = (bus.id_rs1 != 5'd0) &&
             ((ex_load && bus.ex_rd == bus.id_rs1) || (mem_pend && bus.mem_rd == bus.id_rs1));
    haz2   = (bus.id_rs2 != 5'd0) &&
             ((ex_load && bus.ex_rd == bus.id_rs2) || (mem_pend && bus.mem_rd == bus.id_rs2));
    hazard = bus.id_valid & (haz1 | haz2);
  end
  assign bus.id_stall = hazard | ~bus.ex_ready;
  // ID/EX register: hold on backpressure, else flush, bubble on hazard, or capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ex_valid     <= 1'b0;
      bus.ex_reg_write <= 1'b0;
      bus.ex_mem_read  <= 1'b0;
      bus.ex_rd        <= '0;
      bus.ex_op1       <= '0;
      bus.ex_op2       <= '0;
      bus.ex_imm       <= '0;
      bus.ex_pc        <= '0;
      bus.ex_ctrl      <= '0;
    end else if (bus.ex_ready) begin
      if (bus.flush) begin
        bus.ex_valid <= 1'b0;
      end else if (hazard) begin
        bus.ex_valid     <= 1'b0;
        bus.ex_reg_write <= 1'b0;
        bus.ex_mem_read  <= 1'b0;
      end else begin
        bus.ex_valid     <= bus.id_valid;
        bus.ex_reg_write <= bus.id_valid & bus.id_reg_write;
        bus.ex_mem_read  <= bus.id_valid & bus.id_mem_read;
        bus.ex_rd        <= bus.id_rd;
        bus.ex_op1       <= op1;
        bus.ex_op2       <= op2;
        bus.ex_imm       <= bus.id_imm;
        bus.ex_pc        <= bus.id_pc;
        bus.ex_ctrl      <= bus.id_ctrl;
      end
    end
  end
endmodule

// File: tb/tb_operand_stage.sv
// tb_operand_stage: directed scenarios plus randomized run against a rule-level reference model
module tb_operand_stage;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  operand_stage_if #(.XLEN(32), .CTRL_W(8)) bus ();
  operand_stage #(.XLEN(32), .CTRL_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  bit        m_valid, m_rw, m_mr, k_ctl, k_data;
  bit [4:0]  m_rd;
  bit [31:0] m_op1, m_op2, m_imm, m_pc;
  bit [7:0]  m_ctrl;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_imm = 0; bus.id_pc = 0; bus.id_ctrl = 0;
    bus.rf_rdata1 = 0; bus.rf_rdata2 = 0;
    bus.mem_valid = 0; bus.mem_reg_write = 0; bus.mem_fwd_valid = 0; bus.mem_rd = 0; bus.mem_result = 0;
    bus.wb_reg_write = 0; bus.wb_rd = 0; bus.wb_data = 0;
    bus.ex_ready = 1; bus.flush = 0;
  endtask

  // Value a source register must see, following the bypass priority rules
  function automatic bit [31:0] resolve(input bit [4:0] r, input bit [31:0] rf);
    if (r == 0) return 0;
    if (bus.mem_valid && bus.mem_reg_write && bus.mem_fwd_valid && bus.mem_rd == r) return bus.mem_result;
    if (bus.wb_reg_write && bus.wb_rd == r) return bus.wb_data;
    return rf;
  endfunction

  // True when a load whose data is not yet available writes register r
  function automatic bit blocked(input bit [4:0] r);
    if (r == 0) return 0;
    return (m_valid && m_mr && m_rw && m_rd == r) ||
           (bus.mem_valid && bus.mem_reg_write && !bus.mem_fwd_valid && bus.mem_rd == r);
  endfunction

  task automatic test_reset();
    idle();
    bus.id_valid = 1; bus.id_rs1 = 1; bus.rf_rdata1 = 32'h55; bus.id_rd = 3; bus.id_reg_write = 1;
    bus.id_pc = 32'h40; bus.id_ctrl = 8'h3C; bus.id_imm = 32'h9;
    tick();
    checks++; if (bus.ex_valid !== 1'b1 || bus.ex_op1 !== 32'h55) begin errors++;
      $display("FAIL reset_precond valid=%0b op1=%0h exp 1/55", bus.ex_valid, bus.ex_op1); end
    #2 reset = 1;
    #1;
    checks++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read} !== 3'b000) begin errors++;
      $display("FAIL reset_ctl got %b exp 000", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read}); end
    checks++; if ({bus.ex_rd, bus.ex_op1, bus.ex_op2, bus.ex_imm, bus.ex_pc, bus.ex_ctrl} !== '0) begin errors++;
      $display("FAIL reset_data rd=%0h op1=%0h pc=%0h ctrl=%0h exp 0", bus.ex_rd, bus.ex_op1, bus.ex_pc, bus.ex_ctrl); end
    #3 reset = 0;
    idle();
    #1;
    checks++; if (bus.id_stall !== 1'b0) begin errors++;
      $display("FAIL reset_stall got %0b exp 0", bus.id_stall); end
    tick();
  endtask

  task automatic test_wb_bypass();
    idle();
    bus.id_valid = 1; bus.id_rs1 = 5; bus.rf_rdata1 = 32'h11;
    bus.wb_reg_write = 1; bus.wb_rd = 5; bus.wb_data = 32'hAA;
    #1;
    checks++; if (bus.id_stall !== 1'b0) begin errors++;
      $display("FAIL wb_stall got %0b exp 0", bus.id_stall); end
    tick();
    checks++; if (bus.ex_op1 !== 32'hAA || bus.ex_valid !== 1'b1) begin errors++;
      $display("FAIL wb_bypass op1=%0h valid=%0b exp AA/1", bus.ex_op1, bus.ex_valid); end
  endtask

  task automatic test_mem_priority();
    idle();
    bus.id_valid = 1; bus.id_rs1 = 5; bus.rf_rdata1 = 32'h11;
    bus.wb_reg_write = 1; bus.wb_rd = 5; bus.wb_data = 32'hAA;
    bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_fwd_valid = 1; bus.mem_rd = 5; bus.mem_result = 32'hBB;
    tick();
    checks++; if (bus.ex_op1 !== 32'hBB) begin errors++;
      $display("FAIL mem_priority op1=%0h exp BB", bus.ex_op1); end
  endtask

  task automatic test_load_use();
    idle();
    bus.id_valid = 1; bus.id_rd = 7; bus.id_reg_write = 1; bus.id_mem_read = 1;
    tick();
    bus.id_mem_read = 0; bus.id_rd = 8; bus.id_rs2 = 7; bus.rf_rdata2 = 32'hDEAD;
    #1;
    checks++; if (bus.id_stall !== 1'b1) begin errors++;
      $display("FAIL lu_stall1 got %0b exp 1", bus.id_stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++;
      $display("FAIL lu_bubble1 valid=%0b exp 0", bus.ex_valid); end
    bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_rd = 7; bus.mem_fwd_valid = 0;
    #1;
    checks++; if (bus.id_stall !== 1'b1) begin errors++;
      $display("FAIL lu_stall2 got %0b exp 1", bus.id_stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++;
      $display("FAIL lu_bubble2 valid=%0b exp 0", bus.ex_valid); end
    bus.mem_valid = 0; bus.wb_reg_write = 1; bus.wb_rd = 7; bus.wb_data = 32'h1234;
    #1;
    checks++; if (bus.id_stall !== 1'b0) begin errors++;
      $display("FAIL lu_stall3 got %0b exp 0", bus.id_stall); end
    tick();
    checks++; if (bus.ex_op2 !== 32'h1234 || bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd8) begin errors++;
      $display("FAIL lu_forward op2=%0h valid=%0b rd=%0d exp 1234/1/8", bus.ex_op2, bus.ex_valid, bus.ex_rd); end
  endtask

  task automatic test_hold_flush();
    idle();
    bus.id_valid = 1; bus.id_rd = 9; bus.id_reg_write = 1; bus.id_pc = 32'h100; bus.id_ctrl = 8'h5A;
    tick();
    bus.id_rd = 10; bus.id_pc = 32'h200; bus.id_ctrl = 8'hA5; bus.ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.flush = (i == 1);
      #1;
      checks++; if (bus.id_stall !== 1'b1) begin errors++;
        $display("FAIL hold_stall%0d got %0b exp 1", i, bus.id_stall); end
      tick();
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd9 || bus.ex_pc !== 32'h100 || bus.ex_ctrl !== 8'h5A) begin errors++;
        $display("FAIL hold%0d valid=%0b rd=%0d pc=%0h ctrl=%0h exp 1/9/100/5A", i, bus.ex_valid, bus.ex_rd, bus.ex_pc, bus.ex_ctrl); end
    end
  endtask

  task automatic test_flush();
    idle();
    bus.id_valid = 1; bus.id_rd = 4; bus.flush = 1;
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++;
      $display("FAIL flush valid=%0b exp 0", bus.ex_valid); end
  endtask

  task automatic test_x0();
    idle();
    bus.id_valid = 1; bus.rf_rdata1 = 32'h77;
    bus.wb_reg_write = 1; bus.wb_rd = 0; bus.wb_data = 32'hFF;
    bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_fwd_valid = 1; bus.mem_rd = 0; bus.mem_result = 32'hEE;
    tick();
    checks++; if (bus.ex_op1 !== 32'h0) begin errors++;
      $display("FAIL x0_fwd op1=%0h exp 0", bus.ex_op1); end
    idle();
    bus.id_valid = 1; bus.id_rd = 0; bus.id_reg_write = 1; bus.id_mem_read = 1;
    tick();
    bus.id_mem_read = 0; bus.id_rd = 2;
    bus.mem_valid = 1; bus.mem_reg_write = 1; bus.mem_fwd_valid = 0; bus.mem_rd = 0;
    #1;
    checks++; if (bus.id_stall !== 1'b0) begin errors++;
      $display("FAIL x0_load_stall got %0b exp 0", bus.id_stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b1) begin errors++;
      $display("FAIL x0_load_valid got %0b exp 1", bus.ex_valid); end
  endtask

  task automatic test_random();
    bit exp_haz, exp_stall;
    idle();
    reset = 1;
    #3 reset = 0;
    tick();
    {m_valid, m_rw, m_mr, m_rd, m_op1, m_op2, m_imm, m_pc, m_ctrl} = '0;
    k_ctl = 1; k_data = 1;
    for (int n = 0; n < 400; n++) begin
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
      bus.id_rd = 5'($urandom_range(0, 3));
      bus.id_reg_write = 1'($urandom); bus.id_mem_read = 1'($urandom);
      bus.id_imm = $urandom; bus.id_pc = $urandom; bus.id_ctrl = 8'($urandom);
      bus.rf_rdata1 = $urandom; bus.rf_rdata2 = $urandom;
      bus.mem_valid = 1'($urandom); bus.mem_reg_write = 1'($urandom); bus.mem_fwd_valid = 1'($urandom);
      bus.mem_rd = 5'($urandom_range(0, 3)); bus.mem_result = $urandom;
      bus.wb_reg_write = 1'($urandom); bus.wb_rd = 5'($urandom_range(0, 3)); bus.wb_data = $urandom;
      bus.ex_ready = ($urandom_range(0, 3) != 0); bus.flush = ($urandom_range(0, 7) == 0);
      #1;
      exp_haz = bus.id_valid && (blocked(bus.id_rs1) || blocked(bus.id_rs2));
      exp_stall = exp_haz || !bus.ex_ready;
      checks++; if (bus.id_stall !== exp_stall) begin errors++;
        $display("FAIL rnd_stall n=%0d got %0b exp %0b", n, bus.id_stall, exp_stall); end
      if (bus.ex_ready) begin
        if (bus.flush) begin
          m_valid = 0; k_ctl = 0; k_data = 0;
        end else if (exp_haz) begin
          m_valid = 0; m_rw = 0; m_mr = 0; k_ctl = 1; k_data = 0;
        end else begin
          m_valid = bus.id_valid; m_rw = bus.id_valid && bus.id_reg_write; m_mr = bus.id_valid && bus.id_mem_read;
          m_rd = bus.id_rd; m_imm = bus.id_imm; m_pc = bus.id_pc; m_ctrl = bus.id_ctrl;
          m_op1 = resolve(bus.id_rs1, bus.rf_rdata1); m_op2 = resolve(bus.id_rs2, bus.rf_rdata2);
          k_ctl = 1; k_data = 1;
        end
      end
      tick();
      checks++; if (bus.ex_valid !== m_valid) begin errors++;
        $display("FAIL rnd_valid n=%0d got %0b exp %0b", n, bus.ex_valid, m_valid); end
      if (k_ctl) begin
        checks++; if ({bus.ex_reg_write, bus.ex_mem_read} !== {m_rw, m_mr}) begin errors++;
          $display("FAIL rnd_ctl n=%0d got %b exp %b", n, {bus.ex_reg_write, bus.ex_mem_read}, {m_rw, m_mr}); end
      end
      if (k_data) begin
        checks++; if (bus.ex_op1 !== m_op1 || bus.ex_op2 !== m_op2) begin errors++;
          $display("FAIL rnd_ops n=%0d got %0h/%0h exp %0h/%0h", n, bus.ex_op1, bus.ex_op2, m_op1, m_op2); end
        checks++; if (bus.ex_rd !== m_rd || bus.ex_imm !== m_imm || bus.ex_pc !== m_pc || bus.ex_ctrl !== m_ctrl) begin errors++;
          $display("FAIL rnd_fields n=%0d rd=%0d imm=%0h pc=%0h ctrl=%0h exp %0d/%0h/%0h/%0h",
                   n, bus.ex_rd, bus.ex_imm, bus.ex_pc, bus.ex_ctrl, m_rd, m_imm, m_pc, m_ctrl); end
      end
    end
  endtask

  initial begin
    idle();
    #12 reset = 0;
    tick();
    test_reset();
    test_wb_bypass();
    test_mem_priority();
    test_load_use();
    test_hold_flush();
    test_flush();
    test_x0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
